// File: rtl/cello_tt_pkg.sv
// Shared types and sizing helpers for the Cello truth-table extractor.
package cello_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cello_tt_sync.sv
// Multi-flop synchronizer for the asynchronous CUT output.
module cello_tt_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= (sync_q << 1) | STAGES'(d_i);
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cello_tt_extractor.sv
// Sweeps every input row into a Cello CUT, majority-samples its output and
// rebuilds the truth table for comparison against an expected table.
module cello_tt_extractor
  import cello_tt_pkg::*;
#(
  parameter  int N_IN          = 4,
  parameter  int SETTLE_CYCLES = 8,
  parameter  int SAMPLES       = 3,
  parameter  int SYNC_STAGES   = 2,
  localparam int TT_W          = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            tt_valid,
  output logic [TT_W-1:0] tt,
  output logic [TT_W-1:0] unstable_mask,
  output logic [TT_W-1:0] mismatch_mask,
  output logic            match
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int MW = cnt_w(SAMPLES);
  localparam int RW = N_IN + 1;

  if (SETTLE_CYCLES <= SYNC_STAGES) begin : g_bad_settle
    $error("SETTLE_CYCLES must exceed SYNC_STAGES");
  end
  if (N_IN < 2 || N_IN > 6) begin : g_bad_nin
    $error("N_IN must be in 2..6");
  end
  if (SAMPLES < 1 || (SAMPLES % 2) == 0) begin : g_bad_samples
    $error("SAMPLES must be odd and >= 1");
  end

  logic sync_out;

  cello_tt_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (dut_out),
    .q_o (sync_out)
  );

  tt_state_e       state_q, state_d;
  logic [TT_W-1:0] exp_q, exp_d, tt_q, tt_d, unst_q, unst_d, mism_q, mism_d;
  logic            valid_q, valid_d, done_q, done_d, busy_q, busy_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   set_cnt_q, set_cnt_d;
  logic [MW-1:0]   smp_cnt_q, smp_cnt_d, ones_q, ones_d;
  logic [MW-1:0]   ones_sum;
  logic [N_IN-1:0] bit_idx;

  // Row r lands in table bit TT_W-1-r so the hex literal reads row 0 first.
  assign bit_idx  = N_IN'(TT_W - 1) - row_q[N_IN-1:0];
  assign ones_sum = ones_q + MW'(sync_out);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    tt_d      = tt_q;
    unst_d    = unst_q;
    mism_d    = mism_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    stim_d    = stim_q;
    row_d     = row_q;
    set_cnt_d = set_cnt_q;
    smp_cnt_d = smp_cnt_q;
    ones_d    = ones_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = SETTLE;
          exp_d     = expected_tt;
          tt_d      = '0;
          unst_d    = '0;
          mism_d    = '0;
          valid_d   = 1'b0;
          busy_d    = 1'b1;
          stim_d    = '0;
          row_d     = '0;
          set_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          stim_d  = '0;
        end else if (set_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d   = SAMPLE;
          smp_cnt_d = '0;
          ones_d    = '0;
        end else begin
          set_cnt_d = set_cnt_q + SW'(1);
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          stim_d  = '0;
        end else if (smp_cnt_q == MW'(SAMPLES - 1)) begin
          tt_d[bit_idx]   = (ones_sum > MW'(SAMPLES / 2));
          unst_d[bit_idx] = (ones_sum != '0) && (ones_sum != MW'(SAMPLES));
          if (row_q == RW'(TT_W - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            valid_d = 1'b1;
            mism_d  = tt_d ^ exp_q;
            busy_d  = 1'b0;
            stim_d  = '0;
          end else begin
            state_d   = SETTLE;
            row_d     = row_q + RW'(1);
            stim_d    = N_IN'(row_q + RW'(1));
            set_cnt_d = '0;
          end
        end else begin
          smp_cnt_d = smp_cnt_q + MW'(1);
          ones_d    = ones_sum;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      tt_q      <= '0;
      unst_q    <= '0;
      mism_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      stim_q    <= '0;
      row_q     <= '0;
      set_cnt_q <= '0;
      smp_cnt_q <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      tt_q      <= tt_d;
      unst_q    <= unst_d;
      mism_q    <= mism_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      stim_q    <= stim_d;
      row_q     <= row_d;
      set_cnt_q <= set_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      ones_q    <= ones_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tt_valid      = valid_q;
  assign tt            = tt_q;
  assign unstable_mask = unst_q;
  assign mismatch_mask = mism_q;
  assign match         = valid_q && (mism_q == '0);

endmodule

// File: tb/tb_cello_tt_extractor.sv
// Scoreboard bench: a behavioural CUT with injectable sample glitches drives the extractor.
module tb_cello_tt_extractor;

  localparam int N_IN = 4;
  localparam int TT_W = 16;
  localparam int S    = 8;
  localparam int M    = 3;
  localparam int SY   = 2;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [TT_W-1:0] expected_tt;
  logic            dut_out;
  logic [N_IN-1:0] stim;
  logic            busy, done, tt_valid, match;
  logic [TT_W-1:0] tt, unstable_mask, mismatch_mask;

  cello_tt_extractor #(
    .N_IN(N_IN), .SETTLE_CYCLES(S), .SAMPLES(M), .SYNC_STAGES(SY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .expected_tt(expected_tt), .dut_out(dut_out), .stim(stim),
    .busy(busy), .done(done), .tt_valid(tt_valid), .tt(tt),
    .unstable_mask(unstable_mask), .mismatch_mask(mismatch_mask), .match(match)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CUT: row index stim selects table bit TT_W-1-stim.
  logic [TT_W-1:0] cut_tt = 16'h0000;
  logic [N_IN-1:0] cut_idx;
  bit              glitch = 1'b0;
  bit              gl[int];
  assign cut_idx = N_IN'(TT_W - 1) - stim;
  assign dut_out = cut_tt[cut_idx] ^ glitch;

  always @(negedge clk) glitch = gl.exists(cyc + 1);

  typedef struct {
    logic [TT_W-1:0] tt;
    logic [TT_W-1:0] unst;
    logic [TT_W-1:0] mism;
    logic            match;
    int              done_edge;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  bit   prev_done = 1'b0;
  int   g_row[$];
  int   g_smp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
      if (done) begin
        done_seen++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("tt", 32'(tt), 32'(mon_e.tt));
          chk("unstable_mask", 32'(unstable_mask), 32'(mon_e.unst));
          chk("mismatch_mask", 32'(mismatch_mask), 32'(mon_e.mism));
          chk("match", 32'(match), 32'(mon_e.match));
          chk("tt_valid_at_done", 32'(tt_valid), 32'd1);
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("stim_at_done", 32'(stim), 32'd0);
          chk("done_edge", 32'(cyc), 32'(mon_e.done_edge));
        end
      end
      prev_done = done;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_tt"}, 32'(tt), 32'd0);
    chk({tag, "_unst"}, 32'(unstable_mask), 32'd0);
    chk({tag, "_mism"}, 32'(mismatch_mask), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(tt_valid), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_stim"}, 32'(stim), 32'd0);
  endtask

  // One full sweep; glitches listed in g_row/g_smp invert that sample of that row.
  task automatic run_sweep(input logic [TT_W-1:0] cut, input logic [TT_W-1:0] exp_tt,
                           input bit scramble, input bit poke);
    int   k, d0, ones, ed;
    int   flips[TT_W];
    bit   b, got;
    exp_t e;
    cut_tt = cut;
    gl.delete();
    @(negedge clk);
    k = cyc + 1;
    for (int r = 0; r < TT_W; r++) flips[r] = 0;
    for (int i = 0; i < g_row.size(); i++) begin
      ed = k + g_row[i] * (S + M) + S - SY + 1 + g_smp[i];
      if (!gl.exists(ed)) begin
        gl[ed] = 1'b1;
        flips[g_row[i]]++;
      end
    end
    e.tt   = '0;
    e.unst = '0;
    for (int r = 0; r < TT_W; r++) begin
      b    = cut[TT_W-1-r];
      ones = b ? (M - flips[r]) : flips[r];
      e.tt[TT_W-1-r]   = (ones > M / 2);
      e.unst[TT_W-1-r] = (ones != 0) && (ones != M);
    end
    e.mism      = e.tt ^ exp_tt;
    e.match     = (e.mism == '0);
    e.done_edge = k + TT_W * (S + M);
    sbq.push_back(e);
    d0          = done_seen;
    start       = 1'b1;
    expected_tt = exp_tt;
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (scramble) expected_tt = TT_W'($urandom);
      start = poke && (c % 37 == 5);
      @(negedge clk);
      got = (done_seen != d0);
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
    g_row.delete();
    g_smp.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    logic [TT_W-1:0] rc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected_tt = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_sweep(16'h9591, 16'h9591, 1'b0, 1'b0);
    run_sweep(16'h9591, 16'h9599, 1'b0, 1'b0);
    g_row.push_back(5); g_smp.push_back(1);
    run_sweep(16'h9591, 16'h9591, 1'b0, 1'b0);
    run_sweep(16'h0000, 16'h9591, 1'b0, 1'b0);

    // Abort mid-sweep: no done, outputs idle next cycle.
    cut_tt = 16'h9591; gl.delete();
    k = cyc + 1;
    start = 1'b1; expected_tt = 16'h9591;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 49) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stim", 32'(stim), 32'd0);
    chk("abort_valid", 32'(tt_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (200) @(negedge clk);
    run_sweep(16'h9591, 16'h9591, 1'b0, 1'b0);

    // start and abort together in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    repeat (190) @(negedge clk);

    // Starts while busy must not restart the sweep (done timing would slip).
    run_sweep(16'h9591, 16'h9591, 1'b0, 1'b1);

    // Starts while busy, then reset mid-sweep.
    k = cyc + 1;
    start = 1'b1; expected_tt = 16'h9591;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 89) begin
      start = ((cyc - k) % 23 == 7);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (200) @(negedge clk);
    run_sweep(16'h9591, 16'h9591, 1'b0, 1'b0);

    // Randomized tables, expectations, glitches, and drifting expected_tt.
    for (int i = 0; i < 6; i++) begin
      rc = TT_W'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        g_row.push_back(int'($urandom_range(0, TT_W - 1)));
        g_smp.push_back(int'($urandom_range(0, M - 1)));
      end
      run_sweep(rc, ($urandom_range(0, 1) != 0) ? rc : rc ^ TT_W'($urandom), 1'b1, i[0]);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
